// File: rtl/ram16k_arbiter.sv
// Two-port arbiter serialising CPU (A) and DMA/screen (B) accesses onto one RAM16K.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin conflict resolution; default is fixed A priority.
//
// state | meaning
// IDLE  | no access in flight, ram_load low
// ACC_A | latched port A access driving the RAM
// ACC_B | latched port B access driving the RAM
module ram16k_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [13:0] a_addr,
  input  logic [15:0] a_wdata,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic [15:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [13:0] b_addr,
  input  logic [15:0] b_wdata,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic [15:0] b_rdata,
  output logic [15:0] ram_in,
  output logic        ram_load,
  output logic [13:0] ram_address,
  input  logic [15:0] ram_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC_A = 2'd1,
    ACC_B = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        a_win;
  logic        lat_we;
  logic [13:0] lat_addr;
  logic [15:0] lat_wdata;

`ifdef ARB_ROUND_ROBIN_EN
  // High when B should win the next conflict, i.e. A was granted most recently.
  logic prio_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_b <= 1'b0;
    end else if (a_gnt || b_gnt) begin
      prio_b <= a_gnt;
    end
  end

  always_comb begin
    a_win = a_req && (!b_req || !prio_b);
  end
`else
  always_comb begin
    a_win = a_req;
  end
`endif

  // Grants are held off while reset is asserted so nothing transfers on release.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (rst_n) begin
      a_gnt = a_win;
      b_gnt = b_req && !a_win;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = IDLE;
    ram_load    = 1'b0;
    ram_address = lat_addr;
    ram_in      = lat_wdata;
    if (a_gnt) begin
      state_nxt = ACC_A;
    end else if (b_gnt) begin
      state_nxt = ACC_B;
    end
    case (state)
      ACC_A:   ram_load = lat_we;
      ACC_B:   ram_load = lat_we;
      default: ram_load = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_we    <= 1'b0;
      lat_addr  <= 14'd0;
      lat_wdata <= 16'd0;
    end else if (a_gnt) begin
      lat_we    <= a_we;
      lat_addr  <= a_addr;
      lat_wdata <= a_wdata;
    end else if (b_gnt) begin
      lat_we    <= b_we;
      lat_addr  <= b_addr;
      lat_wdata <= b_wdata;
    end
  end

  // Read data is captured on the edge that ends the access cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rvalid <= 1'b0;
      a_rdata  <= 16'd0;
      b_rvalid <= 1'b0;
      b_rdata  <= 16'd0;
    end else begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      if (state == ACC_A && !lat_we) begin
        a_rvalid <= 1'b1;
        a_rdata  <= ram_out;
      end
      if (state == ACC_B && !lat_we) begin
        b_rvalid <= 1'b1;
        b_rdata  <= ram_out;
      end
    end
  end

  a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst_n) !(a_gnt && b_gnt));
  rvalid_onehot : assert property (@(posedge clk) disable iff (!rst_n) !(a_rvalid && b_rvalid));

endmodule

// File: tb/tb_ram16k_arbiter.sv
// Bench for ram16k_arbiter: grant/load vector table plus a read-data scoreboard
// backed by a behavioural RAM16K and a reference memory.
module tb_ram16k_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, a_we, b_req, b_we;
  logic [13:0] a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [15:0] a_rdata, b_rdata;
  logic [15:0] ram_in, ram_out;
  logic        ram_load;
  logic [13:0] ram_address;

  always #5 clk = ~clk;

  ram16k_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_in(ram_in), .ram_load(ram_load), .ram_address(ram_address),
    .ram_out(ram_out)
  );

  // Behavioural RAM16K: combinational read, write on rising edge when loaded.
  logic [15:0] ram [16384];
  logic        ram_init = 1'b0;

  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 16384; i++) ram[i] <= (i < 4) ? 16'(i) : 16'h0000;
      ram_init <= 1'b1;
    end else if (ram_load) begin
      ram[ram_address] <= ram_in;
    end
  end

  assign ram_out = ram[ram_address];

  typedef struct {
    logic        a_req, a_we;
    logic [13:0] a_addr;
    logic [15:0] a_wdata;
    logic        b_req, b_we;
    logic [13:0] b_addr;
    logic [15:0] b_wdata;
    logic        ea_fp, eb_fp, ea_rr, eb_rr, eload;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  vec_t        vecs [14];
  exp_t        aq [$];
  exp_t        bq [$];
  logic [15:0] ref_mem [16384];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic        rst_hit = 1'b0;
  logic        pend_v = 1'b0;
  logic [13:0] pend_addr;
  logic [15:0] pend_data;

  function automatic vec_t mk(logic ar, logic aw, logic [13:0] aa, logic [15:0] ad,
                              logic br, logic bw, logic [13:0] ba, logic [15:0] bd,
                              logic eafp, logic ebfp, logic earr, logic ebrr, logic el);
    vec_t v;
    v.a_req = ar; v.a_we = aw; v.a_addr = aa; v.a_wdata = ad;
    v.b_req = br; v.b_we = bw; v.b_addr = ba; v.b_wdata = bd;
    v.ea_fp = eafp; v.eb_fp = ebfp; v.ea_rr = earr; v.eb_rr = ebrr; v.eload = el;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Runs once per cycle at the falling edge, when inputs and outputs are stable.
  task automatic monitor();
    logic ev;
    cyc++;
    if (!rst_n || rst_hit) begin
      aq.delete();
      bq.delete();
      pend_v  = 1'b0;
      rst_hit = 1'b0;
    end else if (pend_v) begin
      ref_mem[pend_addr] = pend_data;
      pend_v = 1'b0;
    end
    ev = (aq.size() > 0) && (aq[0].due == cyc);
    check("a_rvalid", 32'(a_rvalid), 32'(ev));
    if (ev) begin
      check("a_rdata", 32'(a_rdata), 32'(aq[0].data));
      void'(aq.pop_front());
    end
    ev = (bq.size() > 0) && (bq[0].due == cyc);
    check("b_rvalid", 32'(b_rvalid), 32'(ev));
    if (ev) begin
      check("b_rdata", 32'(b_rdata), 32'(bq[0].data));
      void'(bq.pop_front());
    end
    check("gnt_exclusive", 32'(a_gnt && b_gnt), 32'(0));
    if (rst_n && a_req && a_gnt) begin
      if (a_we) begin
        pend_v = 1'b1; pend_addr = a_addr; pend_data = a_wdata;
      end else begin
        aq.push_back('{data: ref_mem[a_addr], due: cyc + 2});
      end
    end
    if (rst_n && b_req && b_gnt) begin
      if (b_we) begin
        pend_v = 1'b1; pend_addr = b_addr; pend_data = b_wdata;
      end else begin
        bq.push_back('{data: ref_mem[b_addr], due: cyc + 2});
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic r, input logic w, input logic [13:0] ad, input logic [15:0] d);
    a_req = r; a_we = w; a_addr = ad; a_wdata = d;
  endtask

  task automatic set_b(input logic r, input logic w, input logic [13:0] ad, input logic [15:0] d);
    b_req = r; b_we = w; b_addr = ad; b_wdata = d;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    rst_hit = 1'b1;
    #1;
    check("rst_ram_load", 32'(ram_load), 32'(0));
    check("rst_ram_address", 32'(ram_address), 32'(0));
    rst_n = 1'b1;
  endtask

  initial begin
    logic ea, eb;
    for (int i = 0; i < 16384; i++) ref_mem[i] = (i < 4) ? 16'(i) : 16'h0000;

    vecs[0]  = mk(1, 1, 14'h1234, 16'hBEEF, 0, 0, 14'h0000, 16'h0000, 1, 0, 1, 0, 0);
    vecs[1]  = mk(1, 0, 14'h1234, 16'h0000, 0, 0, 14'h0000, 16'h0000, 1, 0, 1, 0, 1);
    vecs[2]  = mk(0, 0, 14'h0000, 16'h0000, 0, 0, 14'h0000, 16'h0000, 0, 0, 0, 0, 0);
    vecs[3]  = mk(0, 0, 14'h0000, 16'h0000, 0, 0, 14'h0000, 16'h0000, 0, 0, 0, 0, 0);
    vecs[4]  = mk(0, 0, 14'h0000, 16'h0000, 1, 1, 14'h3FFF, 16'h0001, 0, 1, 0, 1, 0);
    vecs[5]  = mk(1, 0, 14'h3FFF, 16'h0000, 0, 0, 14'h0000, 16'h0000, 1, 0, 1, 0, 1);
    vecs[6]  = mk(0, 0, 14'h0000, 16'h0000, 1, 0, 14'h0001, 16'h0000, 0, 1, 0, 1, 0);
    for (int i = 7; i < 13; i++) begin
      vecs[i] = mk(1, 0, 14'h0002, 16'h0000, 1, 0, 14'h0003, 16'h0000,
                   1, 0, ((i % 2) == 1), ((i % 2) == 0), 0);
    end
    vecs[13] = mk(0, 0, 14'h0000, 16'h0000, 0, 0, 14'h0000, 16'h0000, 0, 0, 0, 0, 0);

    rst_n = 1'b0;
    set_a(1, 1, 14'h0ABC, 16'hA5A5);
    set_b(1, 0, 14'h0123, 16'h5A5A);
    tick();
    tick();
    check("reset_a_gnt", 32'(a_gnt), 32'(0));
    check("reset_b_gnt", 32'(b_gnt), 32'(0));
    check("reset_ram_load", 32'(ram_load), 32'(0));
    check("reset_ram_address", 32'(ram_address), 32'(0));
    check("reset_ram_in", 32'(ram_in), 32'(0));
    check("reset_a_rdata", 32'(a_rdata), 32'(0));
    check("reset_b_rdata", 32'(b_rdata), 32'(0));
    check("reset_rvalid", 32'({a_rvalid, b_rvalid}), 32'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      set_a(vecs[i].a_req, vecs[i].a_we, vecs[i].a_addr, vecs[i].a_wdata);
      set_b(vecs[i].b_req, vecs[i].b_we, vecs[i].b_addr, vecs[i].b_wdata);
`ifdef ARB_ROUND_ROBIN_EN
      ea = vecs[i].ea_rr; eb = vecs[i].eb_rr;
`else
      ea = vecs[i].ea_fp; eb = vecs[i].eb_fp;
`endif
      #1;
      check($sformatf("vec%0d_a_gnt", i), 32'(a_gnt), 32'(ea));
      check($sformatf("vec%0d_b_gnt", i), 32'(b_gnt), 32'(eb));
      check($sformatf("vec%0d_ram_load", i), 32'(ram_load), 32'(vecs[i].eload));
      tick();
    end

    // Write to 0x0010 aborted by a reset inside its access cycle.
    set_a(1, 1, 14'h0010, 16'h5555);
    set_b(0, 0, 14'h0000, 16'h0000);
    #1;
    check("abort_wr_gnt", 32'(a_gnt), 32'(1));
    tick();
    set_a(0, 0, 14'h0000, 16'h0000);
    #1;
    check("abort_wr_load", 32'(ram_load), 32'(1));
    check("abort_wr_address", 32'(ram_address), 32'(14'h0010));
    check("abort_wr_in", 32'(ram_in), 32'(16'h5555));
    reset_pulse();
    tick();
    set_a(1, 0, 14'h0010, 16'h0000);
    #1;
    check("abort_rd_gnt", 32'(a_gnt), 32'(1));
    tick();
    set_a(0, 0, 14'h0000, 16'h0000);
    tick();
    tick();
    tick();
    check("abort_not_5555", 32'(a_rdata == 16'h5555), 32'(0));

    // Read interrupted by reset must never report rvalid.
    set_a(1, 0, 14'h0001, 16'h0000);
    tick();
    set_a(0, 0, 14'h0000, 16'h0000);
    #1;
    reset_pulse();
    tick();
    tick();
    tick();

    // Back-to-back reads of the pre-loaded words 0..3.
    for (int i = 0; i < 4; i++) begin
      set_a(1, 0, 14'(i), 16'h0000);
      #1;
      check($sformatf("b2b%0d_a_gnt", i), 32'(a_gnt), 32'(1));
      tick();
    end
    set_a(0, 0, 14'h0000, 16'h0000);
    for (int i = 0; i < 4; i++) tick();

    check("scoreboard_drained", 32'(aq.size() + bq.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ram16k_arbiter.md
RAM16K_ARBITER -- requirements
Module: ram16k_arbiter

Interface
REQ-001 Parameters: none; widths fixed at 16-bit data and 14-bit address to match the RAM16K port.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 a_req  in  1  port A (CPU) request valid.
REQ-005 a_we  in  1  port A write enable (1 = write, 0 = read).
REQ-006 a_addr  in  14  port A word address.
REQ-007 a_wdata  in  16  port A write data.
REQ-008 a_gnt  out  1  port A grant; a request transfers on a rising edge with a_req && a_gnt.
REQ-009 a_rvalid  out  1  port A read data valid, one-cycle pulse.
REQ-010 a_rdata  out  16  port A read data, held until the next A read completes.
REQ-011 b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: port B (DMA/screen), same widths and semantics as port A.
REQ-012 ram_in  out  16  to RAM16K in.
REQ-013 ram_load  out  1  to RAM16K load.
REQ-014 ram_address  out  14  to RAM16K address.
REQ-015 ram_out  in  16  from RAM16K out (combinational read).

Function
REQ-016 States: IDLE (no access in flight), ACC_A (port A access driving RAM), ACC_B (port B access driving RAM).
REQ-017 Grants are combinational from the current request inputs and the arbitration policy; at most one of a_gnt/b_gnt is high in any cycle.
REQ-018 A grant is offered in every state, including ACC_A/ACC_B, giving one access per cycle back-to-back.
REQ-019 On a transfer edge, addr/we/wdata of the winner are latched and the next state is ACC_A or ACC_B; with no transfer, the next state is IDLE.
REQ-020 In ACC_x: ram_address = latched addr, ram_in = latched wdata, ram_load = latched we; in IDLE: ram_load = 0, address/in hold their last values.
REQ-021 A write commits in the RAM on the rising edge that ends its ACC cycle; no rvalid is produced for writes.
REQ-022 A read samples ram_out on the edge ending its ACC cycle into x_rdata; x_rvalid is high for exactly the following cycle; latency is 2 cycles from the transfer edge.
REQ-023 A request with no grant shall be held stable by the requester; the arbiter never drops or reorders accepted requests.
REQ-024 Both requests in the same cycle are resolved by the arbitration policy (REQ-029/REQ-030); a lone request is granted immediately.
REQ-025 A read at address X following a write at X (any port) returns the written data, guaranteed by serialised RAM access.

Reset
REQ-026 While rst_n = 0: state IDLE, a_gnt = b_gnt = 0, a_rvalid = b_rvalid = 0, a_rdata = b_rdata = 0, ram_load = 0, ram_address = 0, ram_in = 0, round-robin pointer = A.
REQ-027 Reset asserted mid-access forces ram_load low asynchronously; an in-flight write that has not reached its commit edge is discarded, and no rvalid is issued for an in-flight read.
REQ-028 After rst_n deasserts, the first grant is possible in the first clock cycle.

Configuration
REQ-029 With ARB_ROUND_ROBIN_EN defined: on a conflict, the port not granted most recently wins; the pointer updates only on transfer edges.
REQ-030 Without ARB_ROUND_ROBIN_EN: fixed priority, port A always wins a conflict, and port B may starve.

Verification
REQ-031 Reset: rst_n=0 with a_req=b_req=1 -> both gnt=0, ram_load=0, all outputs 0.
REQ-032 Port A writes 0xBEEF at 0x1234, then reads 0x1234 -> ram_load high one cycle; a_rvalid 2 cycles after the read transfer with a_rdata=0xBEEF.
REQ-033 Both ports request reads continuously for 6 cycles -> RR build: grants alternate A,B,A,B,A,B; fixed build: A granted every cycle and b_gnt=0.
REQ-034 Port B writes 0x0001 at 0x3FFF, then port A reads 0x3FFF in the next cycle -> a_rdata=0x0001, confirming top-bank decoding and ordering.
REQ-035 rst_n pulsed low during ACC_A with a_we=1, data 0x5555 at 0x0010 -> a later read of 0x0010 does not return 0x5555 (pre-loaded 0x0000 expected).
REQ-036 Back-to-back A reads at 0x0000..0x0003 with pre-loaded data 0..3 -> four consecutive a_rvalid pulses carrying 0,1,2,3.
